// File: rtl/core_c1_biu_arb_pkg.sv
// Shared definitions for the c1 bus-interface arbiter.
// Holds the FSM state encoding, the transaction-owner encoding and the
// fixed byte mask used for instruction fetches.
package core_c1_biu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } biu_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } biu_owner_t;

  // Fetches always read a full word.
  localparam logic [3:0] FETCH_WMASK = 4'hF;

  // Width of the starvation counter; holds limits 1..15.
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/core_c1_biu_prio.sv
// Grant selection between fetch and load/store plus the starvation counter.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   if_req_valid    : fetch request pending
//   if_flush        : pc wash; a flushed fetch is not eligible for grant
//   ls_req_valid    : load/store request pending
//   state           : arbiter FSM state; grants only happen in IDLE
//   grant_if/ls     : one-hot grant, valid for the current cycle only
module core_c1_biu_prio
  import core_c1_biu_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req_valid,
  input  logic       if_flush,
  input  logic       ls_req_valid,
  input  biu_state_t state,
  output logic       grant_if,
  output logic       grant_ls
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_reg;
  logic [STARVE_CNT_W-1:0] starve_cnt_next;
  logic                    idle;
  logic                    if_elig;
  logic                    force_if;

  assign idle    = (state == ST_IDLE);
  assign if_elig = if_req_valid & ~if_flush;
  // Once LS has won LIMIT times in a row against a waiting fetch, the next
  // eligible fetch beats LS. A flushed fetch cannot use the slot, so LS keeps it.
  assign force_if = if_elig & (starve_cnt_reg == LIMIT);

  assign grant_ls = idle & ls_req_valid & ~force_if;
  assign grant_if = idle & if_elig & ~grant_ls;

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (grant_ls && if_req_valid) begin
      if (starve_cnt_reg != LIMIT) begin
        starve_cnt_next = starve_cnt_reg + 1'b1;
      end
    end else if (grant_if || (idle && !if_req_valid)) begin
      starve_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

endmodule

// File: rtl/core_c1_biu_arb.sv
// Single-port memory arbiter for the c1 core: shares one memory channel
// between instruction fetch (IF) and load/store (LS), one transaction
// outstanding at a time, and routes each response back to its owner.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   i_if_req_*/o_if_req_ready   : fetch request handshake
//   o_if_rsp_*                  : fetch response (suppressed after a flush)
//   i_if_flush                  : pc wash, kills the in-flight fetch response
//   i_ls_req_*/o_ls_req_ready   : load/store request handshake
//   o_ls_rsp_*                  : load data / store ack
//   o_mem_req_*/i_mem_req_ready : memory request channel
//   i_mem_rsp_*                 : memory response channel
//   o_ifu_pause                 : fetch request pending but not accepted
module core_c1_biu_arb
  import core_c1_biu_arb_pkg::*;
#(
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] RST_PC_ADDR  = 32'h40000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_if_req_valid,
  input  logic [31:0] i_if_req_addr,
  output logic        o_if_req_ready,
  output logic        o_if_rsp_valid,
  output logic [31:0] o_if_rsp_data,
  input  logic        i_if_flush,
  input  logic        i_ls_req_valid,
  input  logic [31:0] i_ls_req_addr,
  input  logic        i_ls_req_wen,
  input  logic [31:0] i_ls_req_wdata,
  input  logic [3:0]  i_ls_req_wmask,
  output logic        o_ls_req_ready,
  output logic        o_ls_rsp_valid,
  output logic [31:0] o_ls_rsp_data,
  output logic        o_mem_req_valid,
  output logic [31:0] o_mem_req_addr,
  output logic        o_mem_req_wen,
  output logic [31:0] o_mem_req_wdata,
  output logic [3:0]  o_mem_req_wmask,
  input  logic        i_mem_req_ready,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  output logic        o_ifu_pause
);

  // RST_PC_ADDR is carried for reference by surrounding code only; this
  // empty block just records that it must be word aligned.
  if (RST_PC_ADDR[1:0] == 2'b00) begin : g_rst_pc_aligned
  end

  biu_state_t  state_reg, state_next;
  biu_owner_t  owner_reg, owner_next;
  logic        drop_reg, drop_next;
  logic [31:0] addr_reg, addr_next;
  logic        wen_reg, wen_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wmask_reg, wmask_next;
  logic        grant_if;
  logic        grant_ls;
  logic        rsp_done;

  core_c1_biu_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (i_if_req_valid),
    .if_flush     (i_if_flush),
    .ls_req_valid (i_ls_req_valid),
    .state        (state_reg),
    .grant_if     (grant_if),
    .grant_ls     (grant_ls)
  );

  assign o_if_req_ready = grant_if;
  assign o_ls_req_ready = grant_ls;
  assign o_ifu_pause    = i_if_req_valid & ~grant_if;

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    drop_next  = drop_reg;
    addr_next  = addr_reg;
    wen_next   = wen_reg;
    wdata_next = wdata_reg;
    wmask_next = wmask_reg;
    rsp_done   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (grant_ls) begin
          addr_next  = i_ls_req_addr;
          wen_next   = i_ls_req_wen;
          wdata_next = i_ls_req_wdata;
          wmask_next = i_ls_req_wmask;
          owner_next = OWN_LS;
          state_next = ST_REQ;
        end else if (grant_if) begin
          addr_next  = i_if_req_addr;
          wen_next   = 1'b0;
          wdata_next = '0;
          wmask_next = FETCH_WMASK;
          owner_next = OWN_IF;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // A response arriving together with the accept completes the
        // transaction in this cycle, skipping WAIT.
        if (i_mem_req_ready) begin
          if (i_mem_rsp_valid) begin
            rsp_done   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_mem_rsp_valid) begin
          rsp_done   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A wash during an outstanding fetch marks its response for silent discard;
    // the memory transaction itself is never retracted.
    if ((state_reg != ST_IDLE) && (owner_reg == OWN_IF) && i_if_flush) begin
      drop_next = 1'b1;
    end
    if (state_next == ST_IDLE) begin
      drop_next  = 1'b0;
      owner_next = OWN_NONE;
    end

    o_mem_req_valid = (state_reg == ST_REQ);
    o_mem_req_addr  = o_mem_req_valid ? addr_reg  : '0;
    o_mem_req_wen   = o_mem_req_valid & wen_reg;
    o_mem_req_wdata = o_mem_req_valid ? wdata_reg : '0;
    o_mem_req_wmask = o_mem_req_valid ? wmask_reg : '0;

    o_ls_rsp_valid  = rsp_done & (owner_reg == OWN_LS);
    o_ls_rsp_data   = o_ls_rsp_valid ? i_mem_rsp_data : '0;
    o_if_rsp_valid  = rsp_done & (owner_reg == OWN_IF) & ~drop_reg & ~i_if_flush;
    o_if_rsp_data   = o_if_rsp_valid ? i_mem_rsp_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWN_NONE;
      drop_reg  <= 1'b0;
      addr_reg  <= '0;
      wen_reg   <= 1'b0;
      wdata_reg <= '0;
      wmask_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      drop_reg  <= drop_next;
      addr_reg  <= addr_next;
      wen_reg   <= wen_next;
      wdata_reg <= wdata_next;
      wmask_reg <= wmask_next;
    end
  end

endmodule
